// File: rtl/bus_arbiter4.sv
// ---------------------------------------------------------------------------
// bus_arbiter4 : round-robin arbiter for a shared 16-bit datapath bus
//
// Four sources (PC, MARMUX, ALU, MDR on the LC-3 datapath) request the bus.
// One registered, one-hot grant is issued at a time. The encoded grant index
// drives the select of an internal mux16_4to1, and the mux output is gated
// to zero whenever no grant is active.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   defined   : an owner that has held the bus for MAX_HOLD cycles is rotated
//               out if any other source is waiting. A lone owner keeps the bus.
//   undefined : the owner keeps the bus until it drops its request.
//               MAX_HOLD is only range-checked in this build.
//
// Parameters
//   MAX_HOLD  max consecutive grant cycles before forced rotation (1..255)
//
// Ports
//   CLK      in   1   system clock, rising edge
//   RST_N    in   1   asynchronous active-low reset
//   REQ      in   4   per-source request, held while the bus is needed
//   D_IN0-3  in   16  source data
//   GNT      out  4   one-hot grant (registered)
//   SEL      out  2   encoded grant index (registered), mux select
//   BUS_OUT  out  16  selected data, 16'h0000 when idle
//   BUS_VLD  out  1   any grant active
// ---------------------------------------------------------------------------

// 4:1 mux of 16-bit words. This is the bus driver that SEL steers.
module mux16_4to1 (
    input  logic [1:0]  sel,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    output logic [15:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module bus_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  REQ,
    input  logic [15:0] D_IN0,
    input  logic [15:0] D_IN1,
    input  logic [15:0] D_IN2,
    input  logic [15:0] D_IN3,
    output logic [3:0]  GNT,
    output logic [1:0]  SEL,
    output logic [15:0] BUS_OUT,
    output logic        BUS_VLD
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter4: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  gnt_nxt;
    logic [1:0]  sel_nxt;
    logic [1:0]  last, last_nxt;
    logic [3:0]  others;
    logic        rr_found;
    logic [1:0]  rr_idx;
    logic        new_grant;
    logic        timeout;
    logic [15:0] mux_y;

    // Round-robin search: first set bit of mask starting at from+1, wrapping.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = from + 2'(k);
            if (!res[2] && mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Candidates for the next grant never include the current owner. In IDLE
    // GNT is zero, so this is simply REQ.
    assign others = REQ & ~GNT;

    always_comb begin
        {rr_found, rr_idx} = rr_pick(others, last);
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;

    // ">=" rather than "==" so a requester that shows up after the count has
    // already passed the limit still forces rotation at the next edge.
    assign timeout = (hold_cnt >= HOLD_LIMIT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_cnt <= 8'd0;
        end else if (new_grant) begin
            hold_cnt <= 8'd0;
        end else if (state == S_GRANT && state_nxt == S_GRANT &&
                     hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state / next-grant logic. A hand-off replaces GNT in a single
    // register update, so there is never a cycle with two bits set and no
    // idle bubble when another source is waiting.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = GNT;
        sel_nxt   = SEL;
        last_nxt  = last;
        new_grant = 1'b0;

        case (state)
            S_IDLE: begin
                if (rr_found) new_grant = 1'b1;
            end
            S_GRANT: begin
                if (!REQ[SEL]) begin
                    if (rr_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        gnt_nxt   = 4'b0000;
                        sel_nxt   = 2'd0;
                    end
                end else if (timeout && rr_found) begin
                    new_grant = 1'b1;
                end
            end
        endcase

        if (new_grant) begin
            state_nxt = S_GRANT;
            gnt_nxt   = 4'b0001 << rr_idx;
            sel_nxt   = rr_idx;
            last_nxt  = rr_idx;
        end
    end

    // LAST resets to 3 so source 0 is first in line after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            GNT   <= 4'b0000;
            SEL   <= 2'd0;
            last  <= 2'd3;
        end else begin
            state <= state_nxt;
            GNT   <= gnt_nxt;
            SEL   <= sel_nxt;
            last  <= last_nxt;
        end
    end

    mux16_4to1 u_mux (
        .sel (SEL),
        .d0  (D_IN0),
        .d1  (D_IN1),
        .d2  (D_IN2),
        .d3  (D_IN3),
        .y   (mux_y)
    );

    assign BUS_VLD = |GNT;
    // Gate after the mux so the idle bus reads zero regardless of SEL.
    assign BUS_OUT = BUS_VLD ? mux_y : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter4.sv
module tb_bus_arbiter4;
    localparam int MAX_HOLD = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  REQ = 4'b0000;
    logic [15:0] D_IN0 = 16'h0, D_IN1 = 16'h0, D_IN2 = 16'h0, D_IN3 = 16'h0;
    logic [3:0]  GNT;
    logic [1:0]  SEL;
    logic [15:0] BUS_OUT;
    logic        BUS_VLD;

    int errors = 0;
    int checks = 0;

    // behavioural reference: owner index (-1 = idle), last winner, hold count
    int m_owner;
    int m_last;
    int m_hold;

    bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
        .D_IN0(D_IN0), .D_IN1(D_IN1), .D_IN2(D_IN2), .D_IN3(D_IN3),
        .GNT(GNT), .SEL(SEL), .BUS_OUT(BUS_OUT), .BUS_VLD(BUS_VLD)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] din(input int i);
        case (i)
            0: return D_IN0;
            1: return D_IN1;
            2: return D_IN2;
            default: return D_IN3;
        endcase
    endfunction

    // next source after 'from' in circular order that has its mask bit set
    function automatic int pick(input logic [3:0] m, input int from);
        for (int k = 1; k <= 4; k++)
            if (m[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_hold = 0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w; m_last = w; m_hold = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] oth;
        int nxt;
        bit rot;
        oth = r;
        if (m_owner >= 0) oth[m_owner] = 1'b0;
        nxt = pick(oth, m_last);
        rot = 0;
        if (m_owner < 0) begin
            if (nxt >= 0) model_grant(nxt);
        end else if (!r[m_owner]) begin
            if (nxt >= 0) model_grant(nxt);
            else m_owner = -1;
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            rot = (nxt >= 0) && (m_hold >= MAX_HOLD - 1);
`endif
            if (rot) model_grant(nxt);
            else if (m_hold < 255) m_hold++;
        end
    endtask

    task automatic step(input logic [3:0] r);
        REQ = r;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        REQ = 4'b0000;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", GNT); end
        checks++; if (SEL !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", SEL); end
        checks++; if (BUS_VLD !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", BUS_VLD); end
        checks++; if (BUS_OUT !== 16'h0000) begin errors++; $display("FAIL reset_bus got=%h exp=0000", BUS_OUT); end
        step(4'b0000);
        checks++; if (GNT !== 4'b0000 || BUS_OUT !== 16'h0000) begin
            errors++; $display("FAIL idle_no_req got gnt=%b bus=%h exp 0000/0000", GNT, BUS_OUT);
        end
    endtask

    task automatic test_single();
        do_reset();
        D_IN0 = 16'hAAAA; D_IN1 = 16'hBBBB; D_IN2 = 16'h0011; D_IN3 = 16'hDDDD;
        step(4'b0100);
        checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", GNT); end
        checks++; if (SEL !== 2'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", SEL); end
        checks++; if (BUS_OUT !== 16'h0011) begin errors++; $display("FAIL single_bus got=%h exp=0011", BUS_OUT); end
        checks++; if (BUS_VLD !== 1'b1) begin errors++; $display("FAIL single_vld got=%b exp=1", BUS_VLD); end
    endtask

    task automatic test_round_robin();
        logic [3:0] reqs [5];
        logic [3:0] exp [5];
        reqs = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(reqs[i]);
            checks++; if (GNT !== exp[i]) begin
                errors++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, GNT, exp[i]);
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        step(4'b0010);
        step(4'b1010);
        checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL handoff_hold got=%b exp=0010", GNT); end
        step(4'b1000);
        checks++; if (GNT !== 4'b1000) begin errors++; $display("FAIL handoff_next got=%b exp=1000", GNT); end
        step(4'b0000);
        checks++; if (GNT !== 4'b0000 || BUS_VLD !== 1'b0) begin
            errors++; $display("FAIL handoff_idle got gnt=%b vld=%b exp 0000/0", GNT, BUS_VLD);
        end
    endtask

    task automatic test_hold_timeout();
        logic [3:0] exp;
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            step(n <= 2 ? 4'b0001 : 4'b0011);
`ifdef BUS_ARB_TIMEOUT_EN
            exp = (n <= MAX_HOLD) ? 4'b0001 : 4'b0010;
`else
            exp = 4'b0001;
`endif
            checks++; if (GNT !== exp) begin
                errors++; $display("FAIL hold_contended[%0d] got=%b exp=%b", n, GNT, exp);
            end
        end
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            step(4'b0001);
            checks++; if (GNT !== 4'b0001) begin
                errors++; $display("FAIL hold_alone[%0d] got=%b exp=0001", n, GNT);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        D_IN1 = 16'h1234;
        step(4'b0010);
        checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL arst_pre got=%b exp=0010", GNT); end
        RST_N = 1'b0;
        #1;
        checks++; if (GNT !== 4'b0000 || BUS_OUT !== 16'h0000 || BUS_VLD !== 1'b0) begin
            errors++; $display("FAIL arst_drop got gnt=%b bus=%h vld=%b exp 0000/0000/0", GNT, BUS_OUT, BUS_VLD);
        end
        REQ = 4'b0011;
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL arst_after got=%b exp=0001", GNT); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] eg;
        logic [1:0] es;
        logic [15:0] eb;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 7) != 0);
            D_IN0 = 16'($urandom); D_IN1 = 16'($urandom);
            D_IN2 = 16'($urandom); D_IN3 = 16'($urandom);
            step(r);
            model_edge(r);
            eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
            eb = (m_owner < 0) ? 16'h0000 : din(m_owner);
            checks++; if (GNT !== eg || SEL !== es || BUS_OUT !== eb || BUS_VLD !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL random[%0d] req=%b got gnt=%b sel=%0d bus=%h vld=%b exp gnt=%b sel=%0d bus=%h",
                         c, r, GNT, SEL, BUS_OUT, BUS_VLD, eg, es, eb);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        test_reset();
        test_single();
        test_round_robin();
        test_handoff();
        test_hold_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
